// File: rtl/multicycle_control_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_control_if                                                      |
// | Control bundle between the multicycle sequencer and the datapath.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       PCWre;
  logic [1:0] PCSrc;
  logic       IRWre;
  logic       InsMemRW;
  logic       RegWre;
  logic [1:0] RegDst;
  logic       WrRegDSrc;
  logic       ALUSrcB;
  logic [2:0] ALUOp;
  logic       ExtSel;
  logic       mRD;
  logic       mWR;
  logic       DBDataSrc;
  logic [2:0] state;

  modport master (
    input  opcode, zero,
    output PCWre, PCSrc, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc,
           ALUSrcB, ALUOp, ExtSel, mRD, mWR, DBDataSrc, state
  );

  modport slave (
    output opcode, zero,
    input  PCWre, PCSrc, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc,
           ALUSrcB, ALUOp, ExtSel, mRD, mWR, DBDataSrc, state
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_control                                                         |
// | IF/ID/EX/MEM/WB sequencer; sole producer of PC write commands.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module multicycle_control (
  input  wire logic         clk,
  input  wire logic         reset,
  multicycle_control_if.master bus
);

  localparam logic [5:0] c_OP_ADD  = 6'b000000;
  localparam logic [5:0] c_OP_SUB  = 6'b000001;
  localparam logic [5:0] c_OP_ADDI = 6'b000010;
  localparam logic [5:0] c_OP_OR   = 6'b010000;
  localparam logic [5:0] c_OP_AND  = 6'b010001;
  localparam logic [5:0] c_OP_ORI  = 6'b010010;
  localparam logic [5:0] c_OP_SLT  = 6'b100110;
  localparam logic [5:0] c_OP_SW   = 6'b110000;
  localparam logic [5:0] c_OP_LW   = 6'b110001;
  localparam logic [5:0] c_OP_BEQ  = 6'b110100;
  localparam logic [5:0] c_OP_J    = 6'b111000;
  localparam logic [5:0] c_OP_JR   = 6'b111001;
  localparam logic [5:0] c_OP_JAL  = 6'b111010;
  localparam logic [5:0] c_OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EXM = 3'b010,
    S_MEM = 3'b011,
    S_WBL = 3'b100,
    S_EXB = 3'b101,
    S_EXA = 3'b110,
    S_WBA = 3'b111
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_halt;
  logic       w_next_halt;
  logic [5:0] r_op_q;
  logic       w_rtype;

  logic       w_pcwre;
  logic [1:0] w_pcsrc;
  logic       w_irwre;
  logic       w_insmemrw;
  logic       w_regwre;
  logic [1:0] w_regdst;
  logic       w_wrregdsrc;
  logic       w_alusrcb;
  logic [2:0] w_aluop;
  logic       w_extsel;
  logic       w_mrd;
  logic       w_mwr;
  logic       w_dbdatasrc;

  assign w_rtype = (r_op_q == c_OP_ADD) || (r_op_q == c_OP_SUB) ||
                   (r_op_q == c_OP_OR)  || (r_op_q == c_OP_AND) ||
                   (r_op_q == c_OP_SLT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IF;
      r_halt  <= 1'b0;
      r_op_q  <= 6'b000000;
    end else begin
      r_state <= w_next;
      r_halt  <= w_next_halt;
      if (r_state == S_ID && !r_halt) begin
        r_op_q <= bus.opcode;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_next_halt = r_halt;
    w_pcwre     = 1'b0;
    w_pcsrc     = 2'b00;
    w_irwre     = 1'b0;
    w_insmemrw  = 1'b0;
    w_regwre    = 1'b0;
    w_regdst    = 2'b00;
    w_wrregdsrc = 1'b0;
    w_alusrcb   = 1'b0;
    w_aluop     = 3'b000;
    w_extsel    = 1'b0;
    w_mrd       = 1'b0;
    w_mwr       = 1'b0;
    w_dbdatasrc = 1'b0;

    case (r_state)
      S_IF: begin
        w_insmemrw = 1'b1;
        w_irwre    = 1'b1;
        w_next     = S_ID;
      end
      S_ID: begin
        // Halted machine parks here with every enable low until reset.
        if (r_halt) begin
          w_next = S_ID;
        end else begin
          case (bus.opcode)
            c_OP_J: begin
              w_pcwre = 1'b1;
              w_pcsrc = 2'b11;
              w_next  = S_IF;
            end
            c_OP_JAL: begin
              w_pcwre     = 1'b1;
              w_pcsrc     = 2'b11;
              w_regwre    = 1'b1;
              w_regdst    = 2'b00;
              w_wrregdsrc = 1'b0;
              w_next      = S_IF;
            end
            c_OP_JR: begin
              w_pcwre = 1'b1;
              w_pcsrc = 2'b10;
              w_next  = S_IF;
            end
            c_OP_HALT: begin
              w_next_halt = 1'b1;
              w_next      = S_ID;
            end
            c_OP_BEQ:                        w_next = S_EXB;
            c_OP_SW, c_OP_LW:                w_next = S_EXM;
            c_OP_ADD, c_OP_SUB, c_OP_ADDI,
            c_OP_OR, c_OP_AND, c_OP_ORI,
            c_OP_SLT:                        w_next = S_EXA;
            default: begin
              w_pcwre = 1'b1;
              w_pcsrc = 2'b00;
              w_next  = S_IF;
            end
          endcase
        end
      end
      S_EXA: begin
        case (r_op_q)
          c_OP_SUB:          w_aluop = 3'b001;
          c_OP_OR, c_OP_ORI: w_aluop = 3'b011;
          c_OP_AND:          w_aluop = 3'b100;
          c_OP_SLT:          w_aluop = 3'b110;
          default:           w_aluop = 3'b000;
        endcase
        w_alusrcb = (r_op_q == c_OP_ADDI) || (r_op_q == c_OP_ORI);
        w_extsel  = (r_op_q == c_OP_ADDI);
        w_next    = S_WBA;
      end
      S_WBA: begin
        w_regwre    = 1'b1;
        w_regdst    = w_rtype ? 2'b10 : 2'b01;
        w_wrregdsrc = 1'b1;
        w_pcwre     = 1'b1;
        w_next      = S_IF;
      end
      S_EXB: begin
        w_aluop  = 3'b001;
        w_extsel = 1'b1;
        w_pcwre  = 1'b1;
        w_pcsrc  = bus.zero ? 2'b01 : 2'b00;
        w_next   = S_IF;
      end
      S_EXM: begin
        w_aluop   = 3'b000;
        w_alusrcb = 1'b1;
        w_extsel  = 1'b1;
        w_next    = S_MEM;
      end
      S_MEM: begin
        if (r_op_q == c_OP_SW) begin
          w_mwr   = 1'b1;
          w_pcwre = 1'b1;
          w_next  = S_IF;
        end else begin
          w_mrd  = 1'b1;
          w_next = S_WBL;
        end
      end
      S_WBL: begin
        w_mrd       = 1'b1;
        w_dbdatasrc = 1'b1;
        w_regwre    = 1'b1;
        w_regdst    = 2'b01;
        w_wrregdsrc = 1'b1;
        w_pcwre     = 1'b1;
        w_next      = S_IF;
      end
      default: w_next = S_IF;
    endcase
  end

  assign bus.PCWre     = w_pcwre;
  assign bus.PCSrc     = w_pcsrc;
  assign bus.IRWre     = w_irwre;
  assign bus.InsMemRW  = w_insmemrw;
  assign bus.RegWre    = w_regwre;
  assign bus.RegDst    = w_regdst;
  assign bus.WrRegDSrc = w_wrregdsrc;
  assign bus.ALUSrcB   = w_alusrcb;
  assign bus.ALUOp     = w_aluop;
  assign bus.ExtSel    = w_extsel;
  assign bus.mRD       = w_mrd;
  assign bus.mWR       = w_mwr;
  assign bus.DBDataSrc = w_dbdatasrc;
  assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_control                                                      |
// | Scoreboard bench: per-cycle expected control words queued per instruction. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_multicycle_control;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwre;
    logic [1:0] pcsrc;
    logic       irwre;
    logic       insmem;
    logic       regwre;
    logic [1:0] regdst;
    logic       wrsrc;
    logic       alusrcb;
    logic [2:0] aluop;
    logic       extsel;
    logic       mrd;
    logic       mwr;
    logic       dbsrc;
  } ctl_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  logic r_prev_pcwre;

  ctl_t  q_exp[$];
  string q_tag[$];

  multicycle_control_if u_if();

  multicycle_control u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ctl_t sample();
    ctl_t c;
    c.st      = u_if.state;
    c.pcwre   = u_if.PCWre;
    c.pcsrc   = u_if.PCSrc;
    c.irwre   = u_if.IRWre;
    c.insmem  = u_if.InsMemRW;
    c.regwre  = u_if.RegWre;
    c.regdst  = u_if.RegDst;
    c.wrsrc   = u_if.WrRegDSrc;
    c.alusrcb = u_if.ALUSrcB;
    c.aluop   = u_if.ALUOp;
    c.extsel  = u_if.ExtSel;
    c.mrd     = u_if.mRD;
    c.mwr     = u_if.mWR;
    c.dbsrc   = u_if.DBDataSrc;
    return c;
  endfunction

  function automatic ctl_t if_rec();
    ctl_t c = '0;
    c.st     = 3'b000;
    c.insmem = 1'b1;
    c.irwre  = 1'b1;
    return c;
  endfunction

  // Expected per-cycle control words for one instruction, written from the opcode tables.
  task automatic push_instr(input logic [5:0] op, input logic z, input string name);
    ctl_t c;
    q_exp.push_back(if_rec()); q_tag.push_back({name, "_IF"});
    c = '0; c.st = 3'b001;
    case (op)
      6'b111000: begin c.pcwre = 1; c.pcsrc = 2'b11; end
      6'b111010: begin c.pcwre = 1; c.pcsrc = 2'b11; c.regwre = 1; c.regdst = 2'b00; end
      6'b111001: begin c.pcwre = 1; c.pcsrc = 2'b10; end
      6'b110100, 6'b110000, 6'b110001,
      6'b000000, 6'b000001, 6'b000010, 6'b010000,
      6'b010001, 6'b010010, 6'b100110: ;
      default:   begin c.pcwre = 1; c.pcsrc = 2'b00; end
    endcase
    q_exp.push_back(c); q_tag.push_back({name, "_ID"});
    case (op)
      6'b110100: begin
        c = '0; c.st = 3'b101; c.aluop = 3'b001; c.extsel = 1; c.pcwre = 1;
        c.pcsrc = z ? 2'b01 : 2'b00;
        q_exp.push_back(c); q_tag.push_back({name, "_EXB"});
      end
      6'b110000, 6'b110001: begin
        c = '0; c.st = 3'b010; c.alusrcb = 1; c.extsel = 1;
        q_exp.push_back(c); q_tag.push_back({name, "_EXM"});
        c = '0; c.st = 3'b011;
        if (op == 6'b110000) begin c.mwr = 1; c.pcwre = 1; end
        else c.mrd = 1;
        q_exp.push_back(c); q_tag.push_back({name, "_MEM"});
        if (op == 6'b110001) begin
          c = '0; c.st = 3'b100; c.mrd = 1; c.dbsrc = 1; c.regwre = 1;
          c.regdst = 2'b01; c.wrsrc = 1; c.pcwre = 1;
          q_exp.push_back(c); q_tag.push_back({name, "_WBL"});
        end
      end
      6'b000000, 6'b000001, 6'b000010, 6'b010000,
      6'b010001, 6'b010010, 6'b100110: begin
        c = '0; c.st = 3'b110;
        case (op)
          6'b000001:            c.aluop = 3'b001;
          6'b010000, 6'b010010: c.aluop = 3'b011;
          6'b010001:            c.aluop = 3'b100;
          6'b100110:            c.aluop = 3'b110;
          default:              c.aluop = 3'b000;
        endcase
        c.alusrcb = (op == 6'b000010 || op == 6'b010010);
        c.extsel  = (op == 6'b000010);
        q_exp.push_back(c); q_tag.push_back({name, "_EXA"});
        c = '0; c.st = 3'b111; c.regwre = 1; c.wrsrc = 1; c.pcwre = 1;
        c.regdst = (op == 6'b000010 || op == 6'b010010) ? 2'b01 : 2'b10;
        q_exp.push_back(c); q_tag.push_back({name, "_WBA"});
      end
      default: ;
    endcase
  endtask

  task automatic step_one();
    ctl_t  e;
    string t;
    #1;
    e = q_exp.pop_front();
    t = q_tag.pop_front();
    check(t, 32'(sample()), 32'(e));
    @(negedge clk);
  endtask

  task automatic drain();
    while (q_exp.size() > 0) step_one();
  endtask

  // PC write discipline and write-port exclusion, checked every cycle out of reset.
  always @(negedge clk) begin
    #3;
    if (!reset) begin
      r_prev_pcwre = 1'b0;
    end else begin
      check("pcwre_in_if", 32'(u_if.PCWre && u_if.state == 3'b000), 32'd0);
      check("pcwre_back2back", 32'(u_if.PCWre && r_prev_pcwre), 32'd0);
      check("regwre_mwr", 32'(u_if.RegWre && u_if.mWR), 32'd0);
      r_prev_pcwre = u_if.PCWre;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [15];
    logic       zs  [15];
    ctl_t       c;
    ops = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
            6'b010010, 6'b100110, 6'b110100, 6'b110100, 6'b110001,
            6'b110000, 6'b111000, 6'b111010, 6'b111001, 6'b000111};
    zs  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    n_cmp = 0;
    n_bad = 0;
    r_prev_pcwre = 1'b0;
    reset = 1'b0;
    u_if.opcode = 6'b000000;
    u_if.zero   = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset_hold", 32'(sample()), 32'(if_rec()));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      u_if.opcode = ops[i];
      u_if.zero   = zs[i];
      push_instr(ops[i], zs[i], $sformatf("op%b_z%0d", ops[i], zs[i]));
      drain();
    end

    // Abort an addi in WBA: reset must return to IF decode without waiting for a clock.
    u_if.opcode = 6'b000010;
    push_instr(6'b000010, 1'b0, "addi_abort");
    repeat (3) step_one();
    #1 begin
      ctl_t e;
      string t;
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      check(t, 32'(sample()), 32'(e));
    end
    reset = 1'b0;
    #1 check("reset_async_if", 32'(sample()), 32'(if_rec()));
    @(negedge clk);
    reset = 1'b1;
    u_if.opcode = 6'b000001;
    push_instr(6'b000001, 1'b0, "sub_after_abort");
    drain();

    u_if.opcode = 6'b111111;
    q_exp.push_back(if_rec()); q_tag.push_back("halt_IF");
    c = '0; c.st = 3'b001;
    for (int k = 0; k < 21; k++) begin
      q_exp.push_back(c); q_tag.push_back($sformatf("halt_cyc%0d", k));
    end
    drain();
    u_if.opcode = 6'b000000;
    #1 check("halt_sticky", 32'(sample()), 32'(c));
    reset = 1'b0;
    #1 check("halt_reset_if", 32'(sample()), 32'(if_rec()));
    @(negedge clk);
    reset = 1'b1;
    u_if.opcode = 6'b111000;
    push_instr(6'b111000, 1'b0, "j_after_halt");
    drain();

    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
